// File: rtl/ftm_nmr_ctrl_pkg.sv
// ftm_nmr_pkg: FSM state type and default sizing shared by the NMR fault-tolerance manager
package ftm_nmr_pkg;
  typedef enum logic [2:0] {RUN, HALT, RECOVER, RST, FAIL} ftm_state_e;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CLEAN_WINDOW = 256;
  localparam int CNT_W = $clog2(DEF_TIMEOUT);
  localparam int CLEAN_W = $clog2(DEF_CLEAN_WINDOW);
endpackage

// File: rtl/ftm_nmr_ctrl_if.sv
// ftm_nmr_ctrl_if: replica write ports, pc/done inputs and recovery/alert outputs; master = core wrapper, slave = controller
interface ftm_nmr_ctrl_if #(
  parameter int NUM_CORES = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic enable_i;
  logic [NUM_CORES-1:0] we_i;
  logic [NUM_CORES*ADDR_W-1:0] waddr_i;
  logic [NUM_CORES*DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] pc_i;
  logic valid_instr_i;
  logic done_i;
  logic recover_o;
  logic reset_o;
  logic recovering_o;
  logic error_o;
  logic alert_minor_o;
  logic alert_major_o;
  logic [NUM_CORES-1:0] fault_mask_o;
  logic [DATA_W-1:0] ckpt_pc_o;
  logic [3:0] retry_cnt_o;
  modport master (
    output enable_i, we_i, waddr_i, wdata_i, pc_i, valid_instr_i, done_i,
    input recover_o, reset_o, recovering_o, error_o, alert_minor_o, alert_major_o, fault_mask_o, ckpt_pc_o, retry_cnt_o
  );
  modport slave (
    input enable_i, we_i, waddr_i, wdata_i, pc_i, valid_instr_i, done_i,
    output recover_o, reset_o, recovering_o, error_o, alert_minor_o, alert_major_o, fault_mask_o, ckpt_pc_o, retry_cnt_o
  );
endinterface

// File: rtl/ftm_nmr_ctrl_voter.sv
// ftm_nmr_voter: combinational majority vote over {we, waddr, wdata} tuples -> mismatch, majority_valid, fault_mask
module ftm_nmr_voter #(
  parameter int NUM_CORES = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [NUM_CORES-1:0] we,
  input  logic [NUM_CORES*ADDR_W-1:0] waddr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic mismatch,
  output logic majority_valid,
  output logic [NUM_CORES-1:0] fault_mask
);
  logic [NUM_CORES-1:0][NUM_CORES-1:0] eq;
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_row
    for (genvar j = 0; j < NUM_CORES; j++) begin : g_col
      assign eq[k][j] = (we[k] == we[j]) && (!we[k] ||
        (waddr[k*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W] &&
         wdata[k*DATA_W +: DATA_W] == wdata[j*DATA_W +: DATA_W]));
    end
  end
  always_comb begin
    mismatch = ~&eq[0];
    majority_valid = 1'b0;
    fault_mask = '1;
    for (int k = 0; k < NUM_CORES; k++) begin
      if ($countones(eq[k]) > NUM_CORES / 2) begin
        majority_valid = 1'b1;
        fault_mask = ~eq[k];
      end
    end
  end
endmodule

// File: rtl/ftm_nmr_ctrl.sv
// ftm_nmr_ctrl: NMR lockstep manager (clk_i, rst_i, bus) - registered vote, pc checkpoint, halt/recover/reset/fail sequencing
module ftm_nmr_ctrl
  import ftm_nmr_pkg::*;
#(
  parameter int NUM_CORES = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int RESET_CYCLES = 4,
  parameter int CLEAN_WINDOW = DEF_CLEAN_WINDOW
) (
  input logic clk_i,
  input logic rst_i,
  ftm_nmr_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int WW = $clog2(CLEAN_WINDOW);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  ftm_state_e st;
  logic v_mis, v_maj, mis_en, mis_q;
  logic [NUM_CORES-1:0] v_mask;
  logic [TW-1:0] timer;
  logic [WW-1:0] clean;
  logic [RW-1:0] rcnt;
  ftm_nmr_voter #(.NUM_CORES(NUM_CORES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_voter (
    .we(bus.we_i), .waddr(bus.waddr_i), .wdata(bus.wdata_i),
    .mismatch(v_mis), .majority_valid(v_maj), .fault_mask(v_mask)
  );
  assign mis_en = v_mis && bus.enable_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st <= RUN;
      mis_q <= 1'b0;
      timer <= '0;
      clean <= '0;
      rcnt <= '0;
      bus.recover_o <= 1'b0;
      bus.reset_o <= 1'b0;
      bus.recovering_o <= 1'b0;
      bus.error_o <= 1'b0;
      bus.alert_minor_o <= 1'b0;
      bus.alert_major_o <= 1'b0;
      bus.fault_mask_o <= '0;
      bus.ckpt_pc_o <= '0;
      bus.retry_cnt_o <= '0;
    end else begin
      mis_q <= 1'b0;
      bus.alert_minor_o <= 1'b0;
      bus.alert_major_o <= 1'b0;
      // a pending mismatch_q freezes the vote so the mask seen during recovery is the one that triggered it
      if (st == RUN && !mis_q && bus.enable_i) begin
        mis_q <= v_mis;
        bus.fault_mask_o <= v_mask;
        bus.alert_minor_o <= v_mis && v_maj;
        bus.alert_major_o <= v_mis && !v_maj;
      end
      if (st == RUN && bus.valid_instr_i && !mis_en) begin
        bus.ckpt_pc_o <= bus.pc_i;
        clean <= (clean == WW'(CLEAN_WINDOW - 1)) ? '0 : clean + 1'b1;
        if (clean == WW'(CLEAN_WINDOW - 1)) bus.retry_cnt_o <= '0;
      end else if (mis_en) begin
        clean <= '0;
      end
      case (st)
        RUN: begin
          if (mis_q && bus.enable_i) begin
            if (bus.retry_cnt_o == 4'(MAX_RETRY)) begin
              st <= FAIL;
              bus.error_o <= 1'b1;
              bus.reset_o <= 1'b1;
            end else begin
              st <= HALT;
              bus.recover_o <= 1'b1;
              bus.retry_cnt_o <= bus.retry_cnt_o + 4'(bus.retry_cnt_o != 4'hf);
            end
          end
        end
        HALT: begin
          st <= RECOVER;
          bus.recover_o <= 1'b0;
          bus.recovering_o <= 1'b1;
          timer <= '0;
        end
        RECOVER: begin
          if (bus.done_i) begin
            st <= RUN;
            bus.recovering_o <= 1'b0;
            bus.fault_mask_o <= '0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            st <= RST;
            bus.recovering_o <= 1'b0;
            bus.reset_o <= 1'b1;
            rcnt <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RST: begin
          if (rcnt == RW'(RESET_CYCLES - 1)) begin
            st <= RUN;
            bus.reset_o <= 1'b0;
            bus.fault_mask_o <= '0;
            timer <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        FAIL: begin
          bus.error_o <= 1'b1;
          bus.reset_o <= 1'b1;
          bus.recover_o <= 1'b0;
          bus.recovering_o <= 1'b0;
        end
        default: st <= RUN;
      endcase
    end
  end
endmodule
